// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//  Single-outstanding APB3 requester. Takes read/write commands on a
//  valid/ready port, runs them on APB (SETUP then ACCESS) and returns read
//  data and error status on a valid/ready response port.
//
//  Optional feature macro: APB_MASTER_TIMEOUT_EN
//    When defined, an ACCESS phase that sees PREADY=0 for TIMEOUT_CYCLES
//    edges is terminated as an error completion (rsp_err=1, rsp_rdata=0).
//
//  Ports
//   PCLK, PRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata  command payload, sampled at the accept edge
//   rsp_valid/rsp_ready   response handshake, response held until accepted
//   rsp_rdata/rsp_err     read data (0 for writes) and completion error
//   PSEL..PWDATA          APB requester outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state, state_nx;
   logic                    psel_nx, penable_nx, pwrite_nx;
   logic [ADDR_WIDTH-1:0]   paddr_nx;
   logic [DATA_WIDTH-1:0]   pwdata_nx;
   logic                    rsp_valid_nx, rsp_err_nx;
   logic [DATA_WIDTH-1:0]   rsp_rdata_nx;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Count value on the edge that would make the wait reach TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nx;
`else
   // TIMEOUT_CYCLES only matters when the timeout feature is built in.
   if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
   end
`endif

   // Only combinational output: commands are accepted exactly in IDLE.
   assign cmd_ready = (state == IDLE);

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_nx     = state;
      psel_nx      = PSEL;
      penable_nx   = PENABLE;
      pwrite_nx    = PWRITE;
      paddr_nx     = PADDR;
      pwdata_nx    = PWDATA;
      rsp_valid_nx = rsp_valid;
      rsp_rdata_nx = rsp_rdata;
      rsp_err_nx   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_nx   = tmo_cnt;
`endif

      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               paddr_nx   = cmd_addr;
               pwrite_nx  = cmd_write;
               pwdata_nx  = cmd_write ? cmd_wdata : '0;
               psel_nx    = 1'b1;
               penable_nx = 1'b0;
               state_nx   = SETUP;
            end
         end

         SETUP: begin
            penable_nx = 1'b1;
            state_nx   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_nx = '0;
`endif
         end

         ACCESS: begin
            if (PREADY) begin
               rsp_rdata_nx = PWRITE ? '0 : PRDATA;
               rsp_err_nx   = PSLVERR;
               rsp_valid_nx = 1'b1;
               psel_nx      = 1'b0;
               penable_nx   = 1'b0;
               state_nx     = RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (tmo_cnt == CNT_LAST) begin
               // Completer never answered: finish as an error completion.
               rsp_rdata_nx = '0;
               rsp_err_nx   = 1'b1;
               rsp_valid_nx = 1'b1;
               psel_nx      = 1'b0;
               penable_nx   = 1'b0;
               tmo_cnt_nx   = tmo_cnt + CNT_W'(1);
               state_nx     = RESP;
            end else begin
               tmo_cnt_nx = tmo_cnt + CNT_W'(1);
            end
`endif
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nx = 1'b0;
               state_nx     = IDLE;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_nx;
         PSEL      <= psel_nx;
         PENABLE   <= penable_nx;
         PWRITE    <= pwrite_nx;
         PADDR     <= paddr_nx;
         PWDATA    <= pwdata_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_rdata <= rsp_rdata_nx;
         rsp_err   <= rsp_err_nx;
`ifdef APB_MASTER_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_nx;
`endif
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//  Self-checking bench: directed table of transactions, hand-written reset and
//  timeout sequences, then random transactions against an APB memory
//  completer and a command-level scoreboard memory.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 16;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;

   int checks = 0;
   int errors = 0;

   always #5 PCLK = ~PCLK;

   apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   // Completer-side memory (written from PWDATA) and command-side scoreboard.
   logic [DW-1:0] slv_mem [logic [AW-1:0]];
   logic [DW-1:0] sb_mem  [logic [AW-1:0]];

   function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
      return slv_mem.exists(a) ? slv_mem[a] : ~a;
   endfunction

   function automatic logic [DW-1:0] sb_rd(input logic [AW-1:0] a);
      return sb_mem.exists(a) ? sb_mem[a] : ~a;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge PCLK);
   endtask

   task automatic chk_idle_bus(input string nm);
      chk({nm, ".psel"}, 64'(PSEL), 64'd0);
      chk({nm, ".penable"}, 64'(PENABLE), 64'd0);
      chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   // One complete command: accept, SETUP, ACCESS with 'waits' PREADY=0 cycles,
   // response held 'hold' cycles with rsp_ready low, then handshake.
   task automatic run_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] prdata,
                          input int waits, input logic serr, input int hold,
                          input logic [DW-1:0] exp_rdata, input logic exp_err,
                          output logic [AW-1:0] cap_addr, output logic [DW-1:0] cap_wdata);
      logic [DW-1:0] exp_pw;
      exp_pw = wr ? wdata : '0;
      chk("pre.cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      step();
      // SETUP: scramble command fields to prove they were captured.
      cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
      chk("setup.psel", 64'(PSEL), 64'd1);
      chk("setup.penable", 64'(PENABLE), 64'd0);
      chk("setup.paddr", 64'(PADDR), 64'(addr));
      chk("setup.pwrite", 64'(PWRITE), 64'(wr));
      chk("setup.pwdata", 64'(PWDATA), 64'(exp_pw));
      chk("setup.cmd_ready", 64'(cmd_ready), 64'd0);
      PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      step();
      for (int i = 0; i <= waits; i++) begin
         chk("access.psel", 64'(PSEL), 64'd1);
         chk("access.penable", 64'(PENABLE), 64'd1);
         chk("access.paddr", 64'(PADDR), 64'(addr));
         chk("access.pwrite", 64'(PWRITE), 64'(wr));
         chk("access.pwdata", 64'(PWDATA), 64'(exp_pw));
         chk("access.rsp_valid", 64'(rsp_valid), 64'd0);
         if (i < waits) begin
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
         end else begin
            PREADY = 1'b1; PRDATA = wr ? DW'($urandom) : prdata; PSLVERR = serr;
            cap_addr = PADDR; cap_wdata = PWDATA;
         end
         step();
      end
      PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      rsp_ready = 1'b0;
      for (int i = 0; i <= hold; i++) begin
         chk("resp.rsp_valid", 64'(rsp_valid), 64'd1);
         chk("resp.rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
         chk("resp.rsp_err", 64'(rsp_err), 64'(exp_err));
         chk("resp.psel", 64'(PSEL), 64'd0);
         chk("resp.penable", 64'(PENABLE), 64'd0);
         chk("resp.cmd_ready", 64'(cmd_ready), 64'd0);
         chk("resp.paddr_kept", 64'(PADDR), 64'(addr));
         if (i < hold) begin
            cmd_valid = 1'b1;
         end else begin
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
         end
         step();
      end
      rsp_ready = 1'b0;
      chk_idle_bus("post");
   endtask

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] prdata;
      int            waits;
      logic          serr;
      int            hold;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t          vecs [6];
   logic [AW-1:0] ca;
   logic [DW-1:0] cw;

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      step(); step();
      chk("rst.psel", 64'(PSEL), 64'd0);
      chk("rst.penable", 64'(PENABLE), 64'd0);
      chk("rst.pwrite", 64'(PWRITE), 64'd0);
      chk("rst.paddr", 64'(PADDR), 64'd0);
      chk("rst.pwdata", 64'(PWDATA), 64'd0);
      chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst.rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst.rsp_err", 64'(rsp_err), 64'd0);
      chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);
      PRESET = 1'b0;
      step();

      // Directed vectors: wr, addr, wdata, prdata, waits, serr, hold, exp_rdata, exp_err
      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        0,  1'b0, 0, 32'h0,        1'b0};
      vecs[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 0,  1'b0, 0, 32'hDEADBEEF, 1'b0};
      vecs[2] = '{1'b0, 32'h20, 32'h0,        32'h12345678, 3,  1'b0, 0, 32'h12345678, 1'b0};
      vecs[3] = '{1'b1, 32'h30, 32'hA5A5A5A5, 32'h0,        0,  1'b1, 5, 32'h0,        1'b1};
      vecs[4] = '{1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 15, 1'b0, 1, 32'hCAFEF00D, 1'b0};
      vecs[5] = '{1'b0, 32'h44, 32'h0,        32'h0BADBEEF, 2,  1'b1, 0, 32'h0BADBEEF, 1'b1};
      for (int v = 0; v < 6; v++)
         run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].prdata, vecs[v].waits,
                 vecs[v].serr, vecs[v].hold, vecs[v].exp_rdata, vecs[v].exp_err, ca, cw);

      // Reset in the middle of ACCESS abandons the transfer.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h11112222;
      step();
      cmd_valid = 1'b0; PREADY = 1'b0;
      step(); step();
      chk("mrst.in_access", 64'(PENABLE), 64'd1);
      PRESET = 1'b1;
      step();
      PRESET = 1'b0;
      chk_idle_bus("mrst");
      chk("mrst.paddr", 64'(PADDR), 64'd0);
      chk("mrst.pwdata", 64'(PWDATA), 64'd0);
      chk("mrst.pwrite", 64'(PWRITE), 64'd0);
      chk("mrst.rsp_err", 64'(rsp_err), 64'd0);
      step(); step();
      chk("mrst.no_rsp", 64'(rsp_valid), 64'd0);
      run_txn(1'b1, 32'h54, 32'h33334444, 32'h0, 1, 1'b0, 0, 32'h0, 1'b0, ca, cw);

      // Completer that never raises PREADY.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; cmd_wdata = '0;
      step();
      cmd_valid = 1'b0; PREADY = 1'b0; PRDATA = 32'hFFFFFFFF;
      step();
      for (int i = 0; i < int'(TMO); i++) begin
         chk("tmo.psel_wait", 64'(PSEL), 64'd1);
         chk("tmo.rsp_wait", 64'(rsp_valid), 64'd0);
         step();
      end
`ifdef APB_MASTER_TIMEOUT_EN
      chk("tmo.psel", 64'(PSEL), 64'd0);
      chk("tmo.penable", 64'(PENABLE), 64'd0);
      chk("tmo.rsp_valid", 64'(rsp_valid), 64'd1);
      chk("tmo.rsp_err", 64'(rsp_err), 64'd1);
      chk("tmo.rsp_rdata", 64'(rsp_rdata), 64'd0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
`else
      chk("notmo.psel", 64'(PSEL), 64'd1);
      chk("notmo.penable", 64'(PENABLE), 64'd1);
      chk("notmo.rsp_valid", 64'(rsp_valid), 64'd0);
      PREADY = 1'b1; PRDATA = 32'h600DF00D; PSLVERR = 1'b0;
      step();
      PREADY = 1'b0;
      chk("notmo.rsp_valid", 64'(rsp_valid), 64'd1);
      chk("notmo.rsp_rdata", 64'(rsp_rdata), 64'h600DF00D);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
`endif
      chk_idle_bus("tmo.end");

      // Random traffic: completer memory vs. command-level scoreboard.
      for (int n = 0; n < 40; n++) begin
         logic          wr, serr;
         logic [AW-1:0] a;
         logic [DW-1:0] wd, er;
         wr   = 1'($urandom);
         a    = 32'h100 + AW'(4 * $urandom_range(0, 7));
         wd   = $urandom;
         serr = ($urandom_range(0, 7) == 0);
         er   = wr ? '0 : sb_rd(a);
         run_txn(wr, a, wd, slv_rd(a), $urandom_range(0, 5), serr, $urandom_range(0, 3),
                 er, serr, ca, cw);
         if (wr) begin
            sb_mem[a]   = wd;
            slv_mem[ca] = cw;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
